// File: rtl/capture_ctrl.sv
// Capture sequencer for the monitor sample memory: circular pre-trigger capture,
// post-trigger count-down, then oldest-first readout over a request/valid handshake.
`timescale 1ns/1ps
module capture_ctrl #(
  parameter int width    = 11,
  parameter int mem_size = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                abort,
  input  logic [mem_size-1:0] probe_i,
  input  logic [mem_size-1:0] trig_mask,
  input  logic [mem_size-1:0] trig_value,
  input  logic [width-1:0]    post_count,
  input  logic                rd_req,
  output logic [mem_size-1:0] rd_data,
  output logic                rd_valid,
  output logic                rd_last,
  output logic                armed,
  output logic                triggered,
  output logic                done,
  output logic [width-1:0]    trig_pos,
  output logic [mem_size-1:0] mem_dat_i,
  output logic                mem_we,
  output logic [width-1:0]    mem_adr,
  input  logic [mem_size-1:0] mem_dat_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [width:0] DEPTH = {1'b1, {width{1'b0}}};

  logic [1:0]          r_state;
  logic [mem_size-1:0] r_probe_q;
  logic [width-1:0]    r_wr_ptr;
  logic                r_wrapped;
  logic [width-1:0]    r_post_len;
  logic [width-1:0]    r_post_cnt;
  logic [width-1:0]    r_trig_adr;
  logic                r_triggered;
  logic [width:0]      r_rd_cnt;
  logic                r_pend;
  logic [mem_size-1:0] r_rd_hold;

  logic                w_writing;
  logic                w_hit;
  logic [width-1:0]    w_oldest;
  logic [width:0]      w_n_samples;
  logic [width-1:0]    w_rd_ptr;
  logic                w_rd_last;

  // Write pointer and wrap flag are frozen in DONE, so the readout window is
  // derived from them directly instead of being copied into separate registers.
  assign w_writing   = (r_state == S_ARMED) || (r_state == S_POST);
  assign w_hit       = ((r_probe_q ^ trig_value) & trig_mask) == '0;
  assign w_oldest    = r_wrapped ? r_wr_ptr : '0;
  assign w_n_samples = r_wrapped ? DEPTH : {1'b0, r_wr_ptr};
  assign w_rd_ptr    = w_oldest + r_rd_cnt[width-1:0];
  assign w_rd_last   = r_pend && (r_rd_cnt == w_n_samples);

  assign mem_we    = w_writing;
  assign mem_dat_i = w_writing ? r_probe_q : '0;
  assign mem_adr   = w_writing ? r_wr_ptr : ((r_state == S_DONE) ? w_rd_ptr : '0);

  assign armed     = w_writing;
  assign triggered = r_triggered;
  assign done      = (r_state == S_DONE);
  assign trig_pos  = (r_state == S_DONE) ? (r_trig_adr - w_oldest) : '0;

  // Memory read data is only present during the pending cycle; hold it afterwards.
  assign rd_valid = r_pend;
  assign rd_last  = w_rd_last;
  assign rd_data  = r_pend ? mem_dat_o : r_rd_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_probe_q <= '0;
    else     r_probe_q <= probe_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_wrapped   <= 1'b0;
      r_post_len  <= '0;
      r_post_cnt  <= '0;
      r_trig_adr  <= '0;
      r_triggered <= 1'b0;
      r_rd_cnt    <= '0;
      r_pend      <= 1'b0;
      r_rd_hold   <= '0;
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_wrapped   <= 1'b0;
      r_post_len  <= '0;
      r_post_cnt  <= '0;
      r_trig_adr  <= '0;
      r_triggered <= 1'b0;
      r_rd_cnt    <= '0;
      r_pend      <= 1'b0;
      r_rd_hold   <= '0;
    end else begin
      if (w_writing) begin
        r_wr_ptr <= r_wr_ptr + width'(1);
        if (r_wr_ptr == '1) r_wrapped <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (arm) begin
            r_state     <= S_ARMED;
            r_wr_ptr    <= '0;
            r_wrapped   <= 1'b0;
            r_post_len  <= post_count;
            r_triggered <= 1'b0;
            r_rd_cnt    <= '0;
          end
        end
        S_ARMED: begin
          if (w_hit) begin
            r_trig_adr  <= r_wr_ptr;
            r_triggered <= 1'b1;
            r_rd_cnt    <= '0;
            if (r_post_len == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state    <= S_POST;
              r_post_cnt <= r_post_len;
            end
          end
        end
        S_POST: begin
          r_post_cnt <= r_post_cnt - width'(1);
          if (r_post_cnt == width'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
          if (r_pend) begin
            r_pend    <= 1'b0;
            r_rd_hold <= mem_dat_o;
            if (w_rd_last) begin
              r_state     <= S_IDLE;
              r_triggered <= 1'b0;
            end
          end else if (rd_req) begin
            r_pend   <= 1'b1;
            r_rd_cnt <= r_rd_cnt + (width+1)'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Self-checking bench for capture_ctrl (width=4): behavioural sample memory,
// ramp probe stimulus and a queue of expected readout words.
`timescale 1ns/1ps
module tb_capture_ctrl;
  localparam int W = 4;
  localparam int D = 32;

  logic         clk = 1'b0;
  logic         rst, arm, abort, rd_req;
  logic [D-1:0] probe_i, trig_mask, trig_value;
  logic [W-1:0] post_count;
  logic [D-1:0] rd_data, mem_dat_i, mem_dat_o;
  logic         rd_valid, rd_last, armed, triggered, done, mem_we;
  logic [W-1:0] trig_pos, mem_adr;

  logic [D-1:0] mem [0:(1<<W)-1];
  logic [D-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_adr] <= mem_dat_i;
    else        mem_dat_o <= mem[mem_adr];
  end

  capture_ctrl #(.width(W), .mem_size(D)) dut (
    .clk(clk), .rst(rst), .arm(arm), .abort(abort), .probe_i(probe_i),
    .trig_mask(trig_mask), .trig_value(trig_value), .post_count(post_count),
    .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
    .armed(armed), .triggered(triggered), .done(done), .trig_pos(trig_pos),
    .mem_dat_i(mem_dat_i), .mem_we(mem_we), .mem_adr(mem_adr), .mem_dat_o(mem_dat_o)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
    probe_i = probe_i + 1;
  endtask

  task automatic start_arm(input logic [D-1:0] mask, input logic [D-1:0] value,
                           input logic [W-1:0] post);
    trig_mask  = mask;
    trig_value = value;
    post_count = post;
    probe_i    = '0;
    arm        = 1'b1;
    cyc();
    arm        = 1'b0;
  endtask

  task automatic run_capture(output int nw);
    nw = 0;
    for (int c = 0; c < 80 && done !== 1'b1; c++) begin
      if (mem_we === 1'b1) begin
        n_cmp++;
        if (mem_adr !== W'(nw) || mem_dat_i !== D'(nw)) begin
          n_err++;
          $display("FAIL write%0d: adr=%0d dat=%0d, expected adr=%0d dat=%0d",
                   nw, mem_adr, mem_dat_i, W'(nw), nw);
        end
        nw++;
      end
      cyc();
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_err++;
      $display("FAIL capture_timeout: done=%b, expected 1", done);
    end
  endtask

  task automatic read_pulsed(input int n);
    logic [D-1:0] e;
    for (int i = 0; i < n; i++) begin
      rd_req = 1'b1;
      cyc();
      rd_req = 1'b0;
      for (int w = 0; w < 4 && rd_valid !== 1'b1; w++) cyc();
      n_cmp++;
      if (rd_valid !== 1'b1) begin
        n_err++;
        $display("FAIL read_timeout%0d: rd_valid=%b, expected 1", i, rd_valid);
        return;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (rd_data !== e) begin
        n_err++;
        $display("FAIL rd_data%0d: got %0d, expected %0d", i, rd_data, e);
      end
      n_cmp++;
      if (rd_last !== (i == n - 1)) begin
        n_err++;
        $display("FAIL rd_last%0d: got %b, expected %b", i, rd_last, (i == n - 1));
      end
      cyc();
      n_cmp++;
      if (rd_valid !== 1'b0 || rd_data !== e) begin
        n_err++;
        $display("FAIL rd_hold%0d: valid=%b data=%0d, expected valid=0 data=%0d",
                 i, rd_valid, rd_data, e);
      end
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_read: done=%b, expected 0", done);
    end
  endtask

  task automatic read_held(input int n);
    logic [D-1:0] e;
    int cnt = 0;
    int last_c = -1;
    rd_req = 1'b1;
    for (int c = 0; c < 4 * n + 8 && cnt < n; c++) begin
      cyc();
      if (rd_valid === 1'b1) begin
        if (cnt > 0) begin
          n_cmp++;
          if (c - last_c != 2) begin
            n_err++;
            $display("FAIL valid_gap%0d: got %0d cycles, expected 2", cnt, c - last_c);
          end
        end
        last_c = c;
        e = exp_q.pop_front();
        n_cmp++;
        if (rd_data !== e) begin
          n_err++;
          $display("FAIL held_data%0d: got %0d, expected %0d", cnt, rd_data, e);
        end
        n_cmp++;
        if (rd_last !== (cnt == n - 1)) begin
          n_err++;
          $display("FAIL held_last%0d: got %b, expected %b", cnt, rd_last, (cnt == n - 1));
        end
        cnt++;
      end
    end
    rd_req = 1'b0;
    n_cmp++;
    if (cnt != n) begin
      n_err++;
      $display("FAIL held_count: got %0d pulses, expected %0d", cnt, n);
    end
    cyc();
    n_cmp++;
    if (done !== 1'b0 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL held_idle: done=%b valid=%b, expected 0 0", done, rd_valid);
    end
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({armed, triggered, done, mem_we, rd_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b, expected 00000",
               {armed, triggered, done, mem_we, rd_valid});
    end
    n_cmp++;
    if (mem_adr !== '0) begin
      n_err++;
      $display("FAIL reset_adr: got %0d, expected 0", mem_adr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_short_capture();
    int nw;
    start_arm('0, '0, W'(3));
    run_capture(nw);
    n_cmp++;
    if (nw != 4) begin
      n_err++;
      $display("FAIL short_writes: got %0d, expected 4", nw);
    end
    n_cmp++;
    if (trig_pos !== W'(0) || triggered !== 1'b1 || armed !== 1'b0) begin
      n_err++;
      $display("FAIL short_status: trig_pos=%0d trig=%b armed=%b, expected 0 1 0",
               trig_pos, triggered, armed);
    end
    for (int v = 0; v < 4; v++) exp_q.push_back(D'(v));
    read_pulsed(4);
  endtask

  task automatic test_wrap();
    int nw;
    start_arm('1, D'(20), W'(5));
    run_capture(nw);
    n_cmp++;
    if (nw != 26) begin
      n_err++;
      $display("FAIL wrap_writes: got %0d, expected 26", nw);
    end
    n_cmp++;
    if (trig_pos !== W'(10)) begin
      n_err++;
      $display("FAIL wrap_trig_pos: got %0d, expected 10", trig_pos);
    end
    for (int v = 10; v < 26; v++) exp_q.push_back(D'(v));
    read_pulsed(16);
  endtask

  task automatic test_back_to_back();
    int nw;
    start_arm('1, D'(20), W'(5));
    run_capture(nw);
    for (int v = 10; v < 26; v++) exp_q.push_back(D'(v));
    read_held(16);
  endtask

  task automatic test_abort();
    int nw;
    logic seen;
    start_arm('0, '0, W'(5));
    repeat (4) cyc();
    n_cmp++;
    if (mem_we !== 1'b1 || mem_adr !== W'(4)) begin
      n_err++;
      $display("FAIL abort_pre: we=%b adr=%0d, expected 1 4", mem_we, mem_adr);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b0 || armed !== 1'b0 || triggered !== 1'b0) begin
      n_err++;
      $display("FAIL abort_stop: we=%b armed=%b trig=%b, expected 0 0 0",
               mem_we, armed, triggered);
    end
    seen = 1'b0;
    repeat (10) begin
      cyc();
      if (done === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL abort_done: done seen=%b, expected 0", seen);
    end
    start_arm('0, '0, '0);
    run_capture(nw);
    n_cmp++;
    if (nw != 1 || trig_pos !== W'(0)) begin
      n_err++;
      $display("FAIL rearm_post0: writes=%0d trig_pos=%0d, expected 1 0", nw, trig_pos);
    end
    exp_q.push_back(D'(0));
    read_pulsed(1);
  endtask

  task automatic test_ignored();
    int nw = 0;
    int after = 0;
    logic seen = 1'b0;
    start_arm('1, D'(12), W'(2));
    for (int c = 0; c < 60 && done !== 1'b1; c++) begin
      n_cmp++;
      if (rd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL ign_valid%0d: got %b, expected 0", c, rd_valid);
      end
      if (mem_we === 1'b1) begin
        n_cmp++;
        if (mem_adr !== W'(nw)) begin
          n_err++;
          $display("FAIL ign_adr%0d: got %0d, expected %0d", nw, mem_adr, W'(nw));
        end
        if (seen) after++;
        if (mem_dat_i === D'(12)) seen = 1'b1;
        nw++;
      end
      arm        = (c == 3);
      rd_req     = (c == 3);
      if (c == 3) post_count = W'(7);
      cyc();
    end
    arm    = 1'b0;
    rd_req = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || after != 2 || nw != 15 || trig_pos !== W'(12)) begin
      n_err++;
      $display("FAIL ign_result: done=%b post=%0d writes=%0d trig_pos=%0d, expected 1 2 15 12",
               done, after, nw, trig_pos);
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL ign_abort: done=%b, expected 0", done);
    end
  endtask

  task automatic test_reset_async();
    int nw;
    start_arm('0, '0, W'(3));
    run_capture(nw);
    rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1) begin
      n_err++;
      $display("FAIL arst_pending: rd_valid=%b, expected 1", rd_valid);
    end
    #3;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({armed, triggered, done, mem_we, rd_valid} !== 5'b0) begin
      n_err++;
      $display("FAIL arst_flags: got %b, expected 00000",
               {armed, triggered, done, mem_we, rd_valid});
    end
    n_cmp++;
    if (mem_adr !== '0) begin
      n_err++;
      $display("FAIL arst_adr: got %0d, expected 0", mem_adr);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc();
    n_cmp++;
    if (done !== 1'b0 || rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL arst_after: done=%b valid=%b, expected 0 0", done, rd_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    arm        = 1'b0;
    abort      = 1'b0;
    rd_req     = 1'b0;
    probe_i    = '0;
    trig_mask  = '0;
    trig_value = '0;
    post_count = '0;
    test_reset();
    test_short_capture();
    test_wrap();
    test_back_to_back();
    test_abort();
    test_ignored();
    test_reset_async();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
